// File: rtl/alu_ctrl_pkg.sv
// Shared constants for the ALU control sequencer: class codes, aluop values,
// the illegal control pattern and the sequencer state enum.
`timescale 1ns/1ps
package alu_ctrl_pkg;

  localparam logic [1:0] CLASS_ARITH  = 2'b00;
  localparam logic [1:0] CLASS_SHIFT  = 2'b01;
  localparam logic [1:0] CLASS_IMM    = 2'b10;
  localparam logic [1:0] CLASS_BRANCH = 2'b11;

  localparam int ALUOP_ARITH  = 0;
  localparam int ALUOP_SHIFT  = 1;
  localparam int ALUOP_IMM    = 4;
  localparam int ALUOP_BRANCH = 6;

  // Wide enough for any CTRL_W; callers truncate to their own width.
  localparam logic [63:0] ILLEGAL_CTRL = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BEAT = 2'd1,
    ITER = 2'd2
  } seq_state_t;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational aluop/funcode decode table producing the control word, the
// illegal flag and a marker for variable shifts (candidates for multi-beat).
`timescale 1ns/1ps
module alu_ctrl_decode
  import alu_ctrl_pkg::*;
#(
  parameter int OP_W   = 4,
  parameter int FUNC_W = 4,
  parameter int CTRL_W = 6
) (
  input  logic [OP_W-1:0]   aluop,
  input  logic [FUNC_W-1:0] funcode,
  output logic [CTRL_W-1:0] control,
  output logic              illegal,
  output logic              var_shift
);

  int         op_val;
  int         fn_val;
  logic [1:0] cls;
  logic       legal;

  assign op_val = int'(aluop);
  assign fn_val = int'(funcode);

  always_comb begin
    cls       = CLASS_ARITH;
    legal     = 1'b0;
    var_shift = 1'b0;
    if (op_val == ALUOP_ARITH && fn_val <= 5) begin
      cls   = CLASS_ARITH;
      legal = 1'b1;
    end else if (op_val == ALUOP_SHIFT && fn_val <= 3) begin
      cls       = CLASS_SHIFT;
      legal     = 1'b1;
      var_shift = (fn_val >= 2);
    end else if (op_val == ALUOP_IMM && (fn_val == 0 || fn_val == 3)) begin
      cls   = CLASS_IMM;
      legal = 1'b1;
    end else if (op_val == ALUOP_BRANCH && fn_val <= 2) begin
      cls   = CLASS_BRANCH;
      legal = 1'b1;
    end
  end

  // Class in the top two bits, funcode in the low bits, zero padding between.
  always_comb begin
    control                 = '0;
    control[CTRL_W-1 -: 2]  = cls;
    control[FUNC_W-1:0]     = funcode;
    if (!legal) begin
      control = ILLEGAL_CTRL[CTRL_W-1:0];
    end
    illegal = !legal;
  end

endmodule

// File: rtl/alu_ctrl_seq.sv
// Request/beat sequencer around the ALU control decoder. Variable shifts with
// shamt > 1 replay the same control beat shamt times. Optional sticky trap on
// illegal ops is enabled by defining ALU_CTRL_ILLEGAL_TRAP_EN.
`timescale 1ns/1ps
module alu_ctrl_seq
  import alu_ctrl_pkg::*;
#(
  parameter int OP_W    = 4,
  parameter int FUNC_W  = 4,
  parameter int CTRL_W  = 6,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [OP_W-1:0]    aluop,
  input  logic [FUNC_W-1:0]  funcode,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CTRL_W-1:0]  control,
  output logic               last,
  output logic               illegal,
  output logic               trap
);

  seq_state_t         state_reg, state_next;
  logic [SHAMT_W-1:0] count_reg, count_next;
  logic [CTRL_W-1:0]  control_reg, control_next;
  logic               last_reg, last_next;
  logic               illegal_reg, illegal_next;

  logic [CTRL_W-1:0]  dec_control;
  logic               dec_illegal;
  logic               dec_var_shift;
  logic               accept;

  alu_ctrl_decode #(
    .OP_W   (OP_W),
    .FUNC_W (FUNC_W),
    .CTRL_W (CTRL_W)
  ) u_decode (
    .aluop     (aluop),
    .funcode   (funcode),
    .control   (dec_control),
    .illegal   (dec_illegal),
    .var_shift (dec_var_shift)
  );

`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
  logic trap_reg, trap_next;
  assign in_ready = (state_reg == IDLE) && !trap_reg;
  assign trap     = trap_reg;
`else
  assign in_ready = (state_reg == IDLE);
  assign trap     = 1'b0;
`endif

  assign accept    = in_valid && in_ready;
  assign out_valid = (state_reg != IDLE);
  assign control   = control_reg;
  assign last      = last_reg;
  assign illegal   = illegal_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      count_reg   <= '0;
      control_reg <= '0;
      last_reg    <= 1'b0;
      illegal_reg <= 1'b0;
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
      trap_reg    <= 1'b0;
`endif
    end else begin
      state_reg   <= state_next;
      count_reg   <= count_next;
      control_reg <= control_next;
      last_reg    <= last_next;
      illegal_reg <= illegal_next;
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
      trap_reg    <= trap_next;
`endif
    end
  end

  always_comb begin
    state_next   = state_reg;
    count_next   = count_reg;
    control_next = control_reg;
    last_next    = last_reg;
    illegal_next = illegal_reg;
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
    trap_next    = trap_reg;
`endif
    unique case (state_reg)
      IDLE: begin
        if (accept) begin
          control_next = dec_control;
          illegal_next = dec_illegal;
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
          trap_next    = trap_reg | dec_illegal;
`endif
          if (dec_var_shift && shamt > SHAMT_W'(1)) begin
            state_next = ITER;
            count_next = shamt;
            last_next  = 1'b0;
          end else begin
            state_next = BEAT;
            count_next = SHAMT_W'(1);
            last_next  = 1'b1;
          end
        end
      end
      // count_reg holds beats still to deliver, including the one on the bus.
      ITER: begin
        if (out_ready) begin
          count_next = count_reg - SHAMT_W'(1);
          if (count_reg == SHAMT_W'(2)) begin
            state_next = BEAT;
            last_next  = 1'b1;
          end
        end
      end
      BEAT: begin
        if (out_ready) begin
          state_next = IDLE;
          count_next = '0;
          last_next  = 1'b0;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Self-checking bench for alu_ctrl_seq: vector table, directed multi-beat and
// reset sequences, and randomized ops against a rule-level reference model.
`timescale 1ns/1ps
module tb_alu_ctrl_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] aluop = '0;
  logic [3:0] funcode = '0;
  logic [4:0] shamt = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [5:0] control;
  logic       last;
  logic       illegal;
  logic       trap;

  int checks = 0;
  int failures = 0;
  bit trap_model = 1'b0;

  alu_ctrl_seq #(.OP_W(4), .FUNC_W(4), .CTRL_W(6), .SHAMT_W(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .aluop     (aluop),
    .funcode   (funcode),
    .shamt     (shamt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .control   (control),
    .last      (last),
    .illegal   (illegal),
    .trap      (trap)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] op;
    logic [3:0] fn;
    logic [4:0] sh;
    logic [5:0] ctrl;
    bit         ill;
    int         beats;
  } vec_t;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endfunction

  // Legality and beat count straight from the opcode rules.
  function automatic void ref_model(input int op, input int fn, input int sh,
                                    output logic [5:0] ctrl, output bit ill, output int beats);
    int cls;
    cls = -1;
    if (op == 0 && fn <= 5) cls = 0;
    else if (op == 1 && fn <= 3) cls = 1;
    else if (op == 4 && (fn == 0 || fn == 3)) cls = 2;
    else if (op == 6 && fn <= 2) cls = 3;
    ill   = (cls < 0);
    ctrl  = ill ? 6'h3f : 6'(cls * 16 + fn);
    beats = (!ill && op == 1 && fn >= 2 && sh > 1) ? sh : 1;
  endfunction

  // mode: 0 = always ready, 1 = toggle 1/0, 2 = random. hold keeps in_valid high.
  task automatic run_op(input logic [3:0] op, input logic [3:0] fn, input logic [4:0] sh,
                        input logic [5:0] ec, input bit ei, input int eb,
                        input int mode, input bit hold);
    int guard;
    int beats;
    int cyc;
    bit r;
    guard = 0;
    while (!in_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk("in_ready_before", in_ready, 1);
    in_valid = 1'b1;
    aluop    = op;
    funcode  = fn;
    shamt    = sh;
    @(negedge clk);
    if (!hold) in_valid = 1'b0;
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
    if (ei) trap_model = 1'b1;
`endif
    beats = 0;
    cyc   = 0;
    while (beats < eb && cyc < 400) begin
      chk("out_valid", out_valid, 1);
      chk("control", control, ec);
      chk("illegal", illegal, ei);
      chk("last", last, (beats == eb - 1));
      chk("in_ready_busy", in_ready, 0);
      chk("trap", trap, trap_model);
      case (mode)
        0:       r = 1'b1;
        1:       r = (cyc % 2 == 0);
        default: r = ($urandom_range(0, 1) == 1);
      endcase
      out_ready = r;
      @(negedge clk);
      if (r) beats++;
      cyc++;
    end
    chk("beat_count", beats, eb);
    chk("out_valid_after", out_valid, 0);
    chk("in_ready_after", in_ready, !trap_model);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    $display("op aluop=%0d funcode=%0d shamt=%0d control=%b illegal=%0d beats=%0d mode=%0d hold=%0d",
             op, fn, sh, ec, ei, eb, mode, hold);
  endtask

  initial begin
    vec_t vecs[11];
    logic [5:0] rc;
    bit ri;
    int rb;
    int op_i, fn_i, sh_i;

    vecs[0]  = '{4'd0, 4'd2, 5'd0, 6'b000010, 1'b0, 1};
    vecs[1]  = '{4'd0, 4'd0, 5'd9, 6'b000000, 1'b0, 1};
    vecs[2]  = '{4'd0, 4'd5, 5'd3, 6'b000101, 1'b0, 1};
    vecs[3]  = '{4'd1, 4'd0, 5'd7, 6'b010000, 1'b0, 1};
    vecs[4]  = '{4'd1, 4'd1, 5'd4, 6'b010001, 1'b0, 1};
    vecs[5]  = '{4'd1, 4'd2, 5'd0, 6'b010010, 1'b0, 1};
    vecs[6]  = '{4'd1, 4'd3, 5'd1, 6'b010011, 1'b0, 1};
    vecs[7]  = '{4'd4, 4'd0, 5'd0, 6'b100000, 1'b0, 1};
    vecs[8]  = '{4'd4, 4'd3, 5'd2, 6'b100011, 1'b0, 1};
    vecs[9]  = '{4'd6, 4'd0, 5'd0, 6'b110000, 1'b0, 1};
    vecs[10] = '{4'd6, 4'd2, 5'd5, 6'b110010, 1'b0, 1};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_control", control, 0);
    chk("rst_last", last, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_trap", trap, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);

    for (int i = 0; i < 11; i++)
      run_op(vecs[i].op, vecs[i].fn, vecs[i].sh, vecs[i].ctrl, vecs[i].ill, vecs[i].beats, 0, 1'b0);

    // Multi-beat with stalls, and in_valid held high during beats
    run_op(4'd1, 4'd3, 5'd3, 6'b010011, 1'b0, 3, 1, 1'b0);
    run_op(4'd0, 4'd2, 5'd0, 6'b000010, 1'b0, 1, 0, 1'b1);
    run_op(4'd1, 4'd3, 5'd3, 6'b010011, 1'b0, 3, 2, 1'b1);
    run_op(4'd1, 4'd2, 5'd2, 6'b010010, 1'b0, 2, 1, 1'b1);

    // out_ready with nothing pending must not start a beat
    out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("idle_ready_noop", out_valid, 0);
    end
    out_ready = 1'b0;

    // Random ops against the reference model
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 4))
        0: op_i = 0;
        1: op_i = 1;
        2: op_i = 4;
        3: op_i = 6;
        default: op_i = $urandom_range(0, 15);
      endcase
      fn_i = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 5);
      sh_i = $urandom_range(0, 7);
      ref_model(op_i, fn_i, sh_i, rc, ri, rb);
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
      if (ri) begin
        op_i = 1; fn_i = 2;
        ref_model(op_i, fn_i, sh_i, rc, ri, rb);
      end
`endif
      run_op(4'(op_i), 4'(fn_i), 5'(sh_i), rc, ri, rb, 2, ($urandom_range(0, 3) == 0));
    end

    // Asynchronous reset during the second beat of a 4-beat shift
    in_valid = 1'b1; aluop = 4'd1; funcode = 4'd2; shamt = 5'd4;
    @(negedge clk);
    in_valid = 1'b0;
    chk("mid_first_valid", out_valid, 1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("mid_second_valid", out_valid, 1);
    chk("mid_second_ctrl", control, 6'b010010);
    chk("mid_second_last", last, 0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_control", control, 0);
    chk("mid_rst_last", last, 0);
    chk("mid_rst_illegal", illegal, 0);
    chk("mid_rst_trap", trap, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rel_in_ready", in_ready, 1);
    chk("mid_rel_out_valid", out_valid, 0);
    $display("op reset during beat 2 of aluop=1 funcode=2 shamt=4");

    // Illegal op handling
    run_op(4'd4, 4'd1, 5'd0, 6'h3f, 1'b1, 1, 0, 1'b0);
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
    in_valid = 1'b1; aluop = 4'd0; funcode = 4'd1; shamt = 5'd0;
    repeat (5) begin
      @(negedge clk);
      chk("trap_in_ready", in_ready, 0);
      chk("trap_sticky", trap, 1);
      chk("trap_no_beat", out_valid, 0);
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    trap_model = 1'b0;
    @(negedge clk);
    chk("trap_cleared", trap, 0);
    chk("trap_in_ready_rel", in_ready, 1);
    $display("op trap held then cleared by reset");
`else
    run_op(4'd6, 4'd1, 5'd0, 6'b110001, 1'b0, 1, 0, 1'b0);
    chk("no_trap", trap, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_ctrl_seq.md
ALU_CTRL_SEQ -- requirements
Module: alu_ctrl_seq

Interface
REQ-001 SHALL have parameter OP_W, default 4, aluop width.
REQ-002 SHALL have parameter FUNC_W, default 4, funcode width.
REQ-003 SHALL have parameter CTRL_W, default 6, control width (>= FUNC_W+2).
REQ-004 SHALL have parameter SHAMT_W, default 5, variable-shift count width.
REQ-005 SHALL have one clock and an asynchronous active-low reset: clk  in  1  rising-edge clock; rst_n  in  1  reset, active low, asynchronous assert.
REQ-006 SHALL have port in_valid  in  1  request valid.
REQ-007 SHALL have port in_ready  out  1  request accepted when in_valid && in_ready.
REQ-008 SHALL have ports aluop  in  OP_W, funcode  in  FUNC_W, shamt  in  SHAMT_W  opcode fields, sampled on acceptance.
REQ-009 SHALL have port out_valid  out  1  control beat valid.
REQ-010 SHALL have port out_ready  in  1  downstream consumes beat.
REQ-011 SHALL have ports control  out  CTRL_W, last  out  1, illegal  out  1  beat payload.
REQ-012 SHALL have port trap  out  1  sticky illegal-op trap.

Function
REQ-013 SHALL decode control = {class[1:0], zero-pad, funcode}; class 00 arith (aluop 0, funcode 0-5), 01 shift (aluop 1, funcode 0-3), 10 immediate (aluop 4, funcode 0 or 3), 11 branch (aluop 6, funcode 0-2).
REQ-014 SHALL treat every other aluop/funcode pair as illegal: control = all ones, illegal = 1.
REQ-015 SHALL implement states IDLE, BEAT, ITER; in_ready = 1 only in IDLE.
REQ-016 SHALL, on acceptance in IDLE, register decoded payload and assert out_valid next cycle (latency 1).
REQ-017 SHALL hold control/last/illegal stable while out_valid && !out_ready.
REQ-018 SHALL treat shift funcode 2 and 3 (variable shifts) with shamt > 1 as multi-beat: shamt identical beats, ITER state, remaining counter decremented per consumed beat, last = 1 only on final beat.
REQ-019 SHALL emit exactly one beat with last = 1 for all other legal ops and for variable shifts with shamt 0 or 1.
REQ-020 SHALL return to IDLE the cycle after the last beat is consumed; no back-to-back acceptance while out_valid is high.
REQ-021 SHALL treat out_ready high with out_valid low as no-op.

Reset
REQ-022 SHALL, on rst_n low at any time including mid-sequence, force state IDLE, out_valid 0, control 0, last 0, illegal 0, trap 0, counter 0, in_ready 1 after release.

Configuration
REQ-023 SHALL, with ALU_CTRL_ILLEGAL_TRAP_EN defined, set trap on acceptance of an illegal op, emit that illegal beat, then hold in_ready 0 until reset.
REQ-024 SHALL, without ALU_CTRL_ILLEGAL_TRAP_EN, tie trap to 0 and continue accepting after illegal beats.

Structure
REQ-025 SHALL place class encodings, aluop constants, ILLEGAL_CTRL value and the state enum in shared package alu_ctrl_pkg.
REQ-026 SHALL put the combinational decode table in sub-module alu_ctrl_decode; sequencing stays in alu_ctrl_seq.

Verification
REQ-027 SHALL cover: aluop 0000 funcode 0010, out_ready 1 -> one beat next cycle, control 6'b000010, last 1, illegal 0.
REQ-028 SHALL cover: aluop 0001 funcode 0011 shamt 3, out_ready toggled 1/0 -> three beats control 6'b010011, last only on third, payload stable during stalls, in_ready 0 throughout.
REQ-029 SHALL cover: aluop 0001 funcode 0010 shamt 0 -> single beat control 6'b010010, last 1.
REQ-030 SHALL cover: aluop 0100 funcode 0001 -> control 6'b111111, illegal 1; with macro trap 1 and in_ready stuck 0, without macro next op aluop 0110 funcode 0001 -> control 6'b110001.
REQ-031 SHALL cover: rst_n asserted during second beat of shamt 4 shift -> out_valid 0, control 0 immediately; in_ready 1 after release.
REQ-032 SHALL cover: in_valid held high while out_valid 1 -> no second acceptance until return to IDLE.
